// File: rtl/vram_fill_if.sv
// Fill-request, VRAM write-port and status signals for vram_fill.
interface vram_fill_if;
    logic       start;
    logic       abort;
    logic [5:0] x0;
    logic [7:0] y0;
    logic [5:0] w;
    logic [8:0] h;
    logic [7:0] fill_byte;
    logic [7:0] fill_color;
    logic       grant;
    logic [15:0] addr;
    logic [7:0] dout;
    logic [7:0] color;
    logic       we;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, x0, y0, w, h, fill_byte, fill_color, grant,
        input  addr, dout, color, we, busy, done
    );

    modport slave (
        input  start, abort, x0, y0, w, h, fill_byte, fill_color, grant,
        output addr, dout, color, we, busy, done
    );
endinterface

// File: rtl/vram_fill.sv
// Rectangle fill engine for a column-major VRAM: one word per granted slot, columns >47 clipped.
// Define VRAM_FILL_PATTERN_EN for a row-alternating dither of the bitmap byte.
module vram_fill (
    input  logic        clk_sys,
    input  logic        reset_n,
    vram_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [5:0] r_x0;
    logic [7:0] r_y0;
    logic [5:0] r_w;
    logic [8:0] r_h;
    logic [7:0] r_byte;
    logic [7:0] r_color;

    // Column is one bit wider than the address field so x0+w overflow stays clipped.
    logic [6:0] r_col;
    logic [7:0] r_row;
    logic [8:0] r_rcnt;
    logic [5:0] r_ccnt;

    logic       w_adv;
    logic       w_clip;
    logic       w_col_end;
    logic       w_last;

    assign w_adv     = (r_state == S_WRITE) && bus.grant && !bus.abort;
    assign w_clip    = (r_col > 7'd47);
    assign w_col_end = (r_rcnt == (r_h - 9'd1));
    assign w_last    = w_col_end && (r_ccnt == (r_w - 6'd1));

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_SETUP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SETUP: begin
                if ((r_w == 6'd0) || (r_h == 9'd0)) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    w_next = S_FINISH;
                end else if (bus.grant && w_last) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the fill request when it is accepted; later input changes are ignored.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_x0    <= 6'd0;
            r_y0    <= 8'd0;
            r_w     <= 6'd0;
            r_h     <= 9'd0;
            r_byte  <= 8'd0;
            r_color <= 8'd0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_x0    <= bus.x0;
            r_y0    <= bus.y0;
            r_w     <= bus.w;
            r_h     <= bus.h;
            r_byte  <= bus.fill_byte;
            r_color <= bus.fill_color;
        end
    end

    // Position counters: rows advance first, then the column steps and the row reloads.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_col  <= 7'd0;
            r_row  <= 8'd0;
            r_rcnt <= 9'd0;
            r_ccnt <= 6'd0;
        end else if (r_state == S_SETUP) begin
            r_col  <= {1'b0, r_x0};
            r_row  <= r_y0;
            r_rcnt <= 9'd0;
            r_ccnt <= 6'd0;
        end else if (w_adv) begin
            if (w_col_end) begin
                r_rcnt <= 9'd0;
                r_row  <= r_y0;
                r_col  <= r_col + 7'd1;
                r_ccnt <= r_ccnt + 6'd1;
            end else begin
                r_rcnt <= r_rcnt + 9'd1;
                r_row  <= r_row + 8'd1;
            end
        end
    end

    assign bus.we    = w_adv && !w_clip;
    assign bus.addr  = 16'h9000 + {2'b00, r_col[5:0], r_row};
    assign bus.color = r_color;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_FINISH);

`ifdef VRAM_FILL_PATTERN_EN
    assign bus.dout  = r_row[0] ? ~r_byte : r_byte;
`else
    assign bus.dout  = r_byte;
`endif

endmodule

// File: tb/tb_vram_fill.sv
// Randomized and directed bench for vram_fill against a slot-indexed rectangle model.
module tb_vram_fill;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    vram_fill_if bus ();

    vram_fill dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_fill(input int x0_i, input int y0_i, input int w_i, input int h_i,
                            input logic [7:0] fb, input logic [7:0] fc,
                            input int gmode, input int abort_after, input bit start_abort);
        int  total;
        int  slot;
        int  nwr;
        int  budget;
        int  col;
        int  row;
        int  eff;
        bit  exp_done;
        bit  fin;
        bit  aborted;
        logic exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_dout;

        total    = w_i * h_i;
        slot     = 0;
        nwr      = 0;
        fin      = 1'b0;
        aborted  = 1'b0;
        exp_done = (total == 0);
        budget   = 4 * total + 20;

        bus.x0 = x0_i[5:0]; bus.y0 = y0_i[7:0]; bus.w = w_i[5:0]; bus.h = h_i[8:0];
        bus.fill_byte = fb; bus.fill_color = fc;
        bus.start = 1'b1; bus.abort = start_abort; bus.grant = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("busy_before_accept", bus.busy, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check("busy_setup", bus.busy, 1'b1);
        check("we_setup", bus.we, 1'b0);
        @(posedge clk); #1;

        for (int k = 2; k < budget && !fin; k++) begin
            bus.x0 = 6'($urandom); bus.y0 = 8'($urandom); bus.w = 6'($urandom);
            bus.h = 9'($urandom); bus.fill_byte = 8'($urandom); bus.fill_color = 8'($urandom);
            bus.start = 1'($urandom_range(0, 1));
            case (gmode)
                0:       bus.grant = 1'b1;
                1:       bus.grant = (k % 2 == 0);
                default: bus.grant = 1'($urandom_range(0, 1));
            endcase
            bus.abort = (abort_after >= 0) && (nwr == abort_after) && !exp_done;
            @(negedge clk);
            check("done", bus.done, exp_done);
            check("busy_run", bus.busy, 1'b1);
            if (exp_done) begin
                check("we_finish", bus.we, 1'b0);
                fin = 1'b1;
            end else begin
                col    = x0_i + slot / h_i;
                row    = (y0_i + slot % h_i) % 256;
                exp_we = bus.grant && !bus.abort && (col <= 47);
                check("we", bus.we, exp_we);
                if (bus.we) begin
                    exp_addr = 16'(32'h9000 + (col % 64) * 256 + row);
`ifdef VRAM_FILL_PATTERN_EN
                    exp_dout = (row % 2 == 1) ? ~fb : fb;
`else
                    exp_dout = fb;
`endif
                    check("addr", bus.addr, exp_addr);
                    check("dout", bus.dout, exp_dout);
                    check("color", bus.color, fc);
                    nwr++;
                end
                if (bus.abort) begin
                    exp_done = 1'b1;
                    aborted  = 1'b1;
                end else if (bus.grant) begin
                    slot++;
                    if (slot == total) exp_done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        check("fill_completed", fin, 1'b1);

        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check("busy_after", bus.busy, 1'b0);
        check("done_after", bus.done, 1'b0);
        check("we_after", bus.we, 1'b0);
        eff = 48 - x0_i;
        if (eff < 0) eff = 0;
        if (w_i < eff) eff = w_i;
        check("nwrites", nwr, aborted ? abort_after : eff * h_i);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.grant = 1'b0;
        bus.x0 = 6'd0; bus.y0 = 8'd0; bus.w = 6'd0; bus.h = 9'd0;
        bus.fill_byte = 8'd0; bus.fill_color = 8'd0;
        #2;
        check("rst_we", bus.we, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_addr", bus.addr, 16'h9000);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_color", bus.color, 8'h00);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Abort while idle must not start anything.
        bus.abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_abort_busy", bus.busy, 1'b0);
            @(posedge clk); #1;
        end
        bus.abort = 1'b0;

        run_fill(0, 0, 1, 4, 8'hAA, 8'h70, 0, -1, 1'b0);
        run_fill(46, 254, 3, 3, 8'h5A, 8'h12, 0, -1, 1'b0);
        run_fill(10, 20, 2, 2, 8'hC3, 8'h34, 1, -1, 1'b0);
        run_fill(5, 0, 1, 256, 8'h0F, 8'h56, 0, -1, 1'b0);
        run_fill(0, 0, 48, 256, 8'hFF, 8'h78, 0, 100, 1'b0);
        run_fill(3, 3, 0, 5, 8'h11, 8'h9A, 0, -1, 1'b0);
        run_fill(0, 0, 4, 0, 8'h22, 8'hBC, 0, -1, 1'b0);
        run_fill(7, 9, 2, 3, 8'h81, 8'hDE, 2, -1, 1'b1);

        // Asynchronous reset in the middle of a fill.
        bus.x0 = 6'd0; bus.y0 = 8'd0; bus.w = 6'd4; bus.h = 9'd4;
        bus.fill_byte = 8'h3C; bus.fill_color = 8'h77;
        bus.start = 1'b1; bus.grant = 1'b1; bus.abort = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_we", bus.we, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_addr", bus.addr, 16'h9000);
        check("mid_rst_dout", bus.dout, 8'h00);
        check("mid_rst_color", bus.color, 8'h00);
        @(negedge clk);
        check("mid_rst_done_neg", bus.done, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", bus.busy, 1'b0);
            check("post_rst_done", bus.done, 1'b0);
            @(posedge clk); #1;
        end
        run_fill(0, 0, 1, 1, 8'h99, 8'h44, 0, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_fill(int'($urandom_range(0, 55)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
